// File: rtl/switch_arb_pkg.sv
// Shared types and the round-robin pick helper for the switch injection arbiter.
// Index widths are sized for up to MAX_PORTS requesters.
package switch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_HI,
        WAIT_LO
    } arb_state_e;

    localparam int MAX_PORTS = 32;
    localparam int PTR_W     = $clog2(MAX_PORTS);

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at ports-1 back to 0.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] valid,
                                         input logic [PTR_W-1:0]     ptr,
                                         input int                   ports);
        rr_pick_t         res;
        int               pos;
        logic [PTR_W-1:0] sel;
        res = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            pos = (int'(ptr) + k) % ports;
            sel = PTR_W'(pos);
            if (k < ports && !res.found && valid[sel]) begin
                res.found = 1'b1;
                res.idx   = sel;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/switch_ack_sync.sv
// Multi-flop synchroniser bringing the switch's asynchronous acknowledge into the clk domain.
module switch_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_inject_arbiter.sv
// Round-robin packet arbiter driving a 4-phase bundled-data switch input port.
// Optional watchdog on the handshake wait states is enabled by defining SWITCH_ARB_WATCHDOG_EN.
module switch_inject_arbiter
    import switch_arb_pkg::*;
#(
    parameter int WIDTH          = 128,
    parameter int PORTS          = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PORTS-1:0]       src_valid_i,
    input  logic [PORTS*WIDTH-1:0] src_data_i,
    input  logic [PORTS-1:0]       src_tail_i,
    output logic [PORTS-1:0]       src_ready_o,
    output logic [PORTS-1:0]       grant_o,
    output logic                   req_o,
    output logic [WIDTH-1:0]       data_o,
    input  logic                   ack_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    arb_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] ready_q, ready_d;
    logic             tail_q, tail_d;
    logic             busy_q, busy_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] owner_q, owner_d;

    logic                 ack_s;
    logic [MAX_PORTS-1:0] valid_ext;
    logic [MAX_PORTS-1:0] tail_ext;
    rr_pick_t             pick;
    logic                 locked;
    logic                 owner_valid;
    logic                 capture;
    logic [PTR_W-1:0]     cap_idx;

    switch_ack_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(ack_i),
        .sync_o (ack_s)
    );

    assign valid_ext   = MAX_PORTS'(src_valid_i);
    assign tail_ext    = MAX_PORTS'(src_tail_i);
    assign locked      = |grant_q;
    assign owner_valid = valid_ext[owner_q];

    always_comb begin
        pick = rr_pick(valid_ext, rr_q, PORTS);
    end

    // A nonzero grant means a packet is locked: only its owner may be captured until the tail completes.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        grant_d = grant_q;
        ready_d = '0;
        tail_d  = tail_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        capture = 1'b0;
        cap_idx = owner_q;

        case (state_q)
            IDLE: begin
                if (locked) begin
                    capture = owner_valid;
                end else if (pick.found) begin
                    capture = 1'b1;
                    cap_idx = pick.idx;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    if (tail_q) begin
                        grant_d = '0;
                        rr_d    = (owner_q == PTR_W'(PORTS - 1)) ? '0 : owner_q + PTR_W'(1);
                        state_d = IDLE;
                    end else if (owner_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Data is loaded a full cycle before req rises so the bundle is settled at the switch.
        if (capture) begin
            owner_d = cap_idx;
            data_d  = src_data_i[int'(cap_idx)*WIDTH +: WIDTH];
            ready_d = PORTS'(1) << cap_idx;
            grant_d = PORTS'(1) << cap_idx;
            tail_d  = tail_ext[cap_idx];
            state_d = SETUP;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ready_q <= '0;
            tail_q  <= 1'b0;
            busy_q  <= 1'b0;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            tail_q  <= tail_d;
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    assign req_o       = req_q;
    assign data_o      = data_q;
    assign grant_o     = grant_q;
    assign src_ready_o = ready_q;
    assign busy_o      = busy_q;

`ifdef SWITCH_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;

    // Counts cycles spent waiting on one handshake phase; saturates at the limit, flag is sticky.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_d != state_q && (state_d == WAIT_HI || state_d == WAIT_LO)) begin
            wd_cnt_d = '0;
        end else if (state_q == WAIT_HI || state_q == WAIT_LO) begin
            if (wd_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
            if (wd_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_switch_inject_arbiter.sv
// Directed bench for switch_inject_arbiter: source and 4-phase switch models, vector table for arbitration order.
module tb_switch_inject_arbiter;

    localparam int W     = 128;
    localparam int P     = 5;
    localparam int TO    = 16;

`ifdef SWITCH_ARB_WATCHDOG_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic [P-1:0]   src_valid_i;
    logic [P*W-1:0] src_data_i;
    logic [P-1:0]   src_tail_i;
    logic [P-1:0]   src_ready_o;
    logic [P-1:0]   grant_o;
    logic           req_o;
    logic [W-1:0]   data_o;
    logic           ack_i;
    logic           busy_o;
    logic           timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    // Source model: each source sends flits flit_no..pkt_len-1; hold stalls its valid.
    int          pkt_len [P];
    int          flit_no [P];
    logic [31:0] seed    [P];
    logic        hold    [P];
    logic        ack_auto;
    int          srv_src[$];

    typedef struct {
        logic [P-1:0] mask;
        logic [31:0]  sd;
        logic [P-1:0] exp;
    } vec_t;
    vec_t vecs[12];

    switch_inject_arbiter #(
        .WIDTH(W), .PORTS(P), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid_i(src_valid_i),
        .src_data_i (src_data_i),
        .src_tail_i (src_tail_i),
        .src_ready_o(src_ready_o),
        .grant_o    (grant_o),
        .req_o      (req_o),
        .data_o     (data_o),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [31:0] s, input int i, input int f);
        logic [31:0] w;
        w = s + 32'(i * 16 + f);
        return {4{w}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < P; i++) begin
            src_valid_i[i]           = !hold[i] && (flit_no[i] < pkt_len[i]);
            src_data_i[i*W +: W]     = mk(seed[i], i, flit_no[i]);
            src_tail_i[i]            = (flit_no[i] == pkt_len[i] - 1);
        end
    endtask

    // One clock: log any capture, advance the captured source, respond to req like the switch.
    task automatic step();
        int idx;
        @(negedge clk);
        if (src_ready_o != '0) begin
            idx = 0;
            for (int i = P - 1; i >= 0; i--) if (src_ready_o[i]) idx = i;
            check("cap_onehot", W'($onehot(src_ready_o)), W'(1));
            check("cap_grant", W'(grant_o), W'(src_ready_o));
            check("cap_data", data_o, mk(seed[idx], idx, flit_no[idx]));
            srv_src.push_back(idx);
            flit_no[idx]++;
        end
        ack_i = ack_auto ? req_o : 1'b0;
        drive();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < P; i++) begin
            pkt_len[i] = 0;
            flit_no[i] = 0;
            seed[i]    = 32'h0;
            hold[i]    = 1'b0;
        end
        drive();
    endtask

    task automatic load(input int i, input int len, input logic [31:0] s);
        pkt_len[i] = flit_no[i] + len;
        seed[i]    = s;
        drive();
    endtask

    task automatic wait_capture(input int target, input int budget);
        int n = 0;
        while (srv_src.size() < target && n < budget) begin
            step();
            n++;
        end
        check("capture_in_time", W'(srv_src.size() >= target), W'(1));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step();
        while (busy_o && n < budget) begin
            step();
            n++;
        end
        check("idle_in_time", W'(busy_o), W'(0));
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!req_o && n < budget) begin
            step();
            n++;
        end
        check("req_in_time", W'(req_o), W'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_sources();
        ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [P-1:0] onehot(input int i);
        logic [P-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int  base;
        int  got;
        logic ok;

        vecs[0]  = '{5'b11111, 32'h1000_0000, 5'b00001};
        vecs[1]  = '{5'b11111, 32'h1100_0000, 5'b00010};
        vecs[2]  = '{5'b11111, 32'h1200_0000, 5'b00100};
        vecs[3]  = '{5'b11111, 32'h1300_0000, 5'b01000};
        vecs[4]  = '{5'b11111, 32'h1400_0000, 5'b10000};
        vecs[5]  = '{5'b11111, 32'h1500_0000, 5'b00001};
        vecs[6]  = '{5'b10000, 32'h1600_0000, 5'b10000};
        vecs[7]  = '{5'b01100, 32'h1700_0000, 5'b00100};
        vecs[8]  = '{5'b00011, 32'h1800_0000, 5'b00001};
        vecs[9]  = '{5'b00001, 32'h1900_0000, 5'b00001};
        vecs[10] = '{5'b11000, 32'h1A00_0000, 5'b01000};
        vecs[11] = '{5'b01001, 32'h1B00_0000, 5'b00001};

        reset    = 1'b0;
        ack_i    = 1'b0;
        ack_auto = 1'b1;
        clear_sources();
        #1 reset = 1'b1;
        #1;
        check("rst_req", W'(req_o), W'(0));
        check("rst_grant", W'(grant_o), W'(0));
        check("rst_ready", W'(src_ready_o), W'(0));
        check("rst_busy", W'(busy_o), W'(0));
        check("rst_data", data_o, W'(0));
        check("rst_timeout", W'(timeout_o), W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single-flit packet from source 2 with the A5 pattern.
        base = srv_src.size();
        load(2, 1, 32'hA5A5_A585);
        step();
        check("t2_cap_latency", W'(srv_src.size()), W'(base + 1));
        check("t2_ready", W'(src_ready_o), W'(5'b00100));
        check("t2_data", data_o, {16{8'hA5}});
        check("t2_req_before", W'(req_o), W'(0));
        step();
        check("t2_ready_once", W'(src_ready_o), W'(0));
        check("t2_req_up", W'(req_o), W'(1));
        ok = 1'b1;
        for (int n = 0; n < 30 && busy_o; n++) begin
            if (data_o !== {16{8'hA5}}) ok = 1'b0;
            step();
        end
        check("t2_data_held", W'(ok), W'(1));
        check("t2_idle", W'(busy_o), W'(0));
        check("t2_grant_rel", W'(grant_o), W'(0));

        // Pointer now 3: with everyone requesting, source 3 wins.
        base = srv_src.size();
        for (int i = 0; i < P; i++) load(i, 1, 32'h2000_0000);
        wait_capture(base + 1, 20);
        if (srv_src.size() > base) check("t2_rr_ptr3", W'(srv_src[base]), W'(3));
        clear_sources();
        wait_idle(40);

        // Reset while the FSM waits for ack high.
        ack_auto = 1'b0;
        load(3, 1, 32'h3000_0000);
        wait_req(20);
        reset = 1'b1;
        #1;
        check("t1_req", W'(req_o), W'(0));
        check("t1_grant", W'(grant_o), W'(0));
        check("t1_busy", W'(busy_o), W'(0));
        clear_sources();
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        ack_auto = 1'b1;
        ok = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (req_o || busy_o) ok = 1'b0;
        end
        check("t1_no_spurious", W'(ok), W'(1));

        // Arbitration order from a fresh pointer, including wrap-around cases.
        for (int e = 0; e < 12; e++) begin
            base = srv_src.size();
            for (int i = 0; i < P; i++) if (vecs[e].mask[i]) load(i, 1, vecs[e].sd);
            wait_capture(base + 1, 20);
            got = (srv_src.size() > base) ? srv_src[base] : 0;
            check($sformatf("rr_vec%0d", e), W'(onehot(got)), W'(vecs[e].exp));
            step();
            check($sformatf("rr_ready_once%0d", e), W'(src_ready_o), W'(0));
            for (int i = 0; i < P; i++) if (i != got) pkt_len[i] = flit_no[i];
            drive();
            wait_idle(40);
            check($sformatf("rr_release%0d", e), W'(grant_o), W'(0));
        end

        // Lock: 3-flit packet from source 1 is not interleaved with 0 or 4.
        base = srv_src.size();
        load(1, 3, 32'h4100_0000);
        load(0, 1, 32'h4000_0000);
        load(4, 1, 32'h4400_0000);
        wait_capture(base + 5, 200);
        if (srv_src.size() >= base + 5) begin
            check("t4_f0", W'(srv_src[base]), W'(1));
            check("t4_f1", W'(srv_src[base + 1]), W'(1));
            check("t4_f2", W'(srv_src[base + 2]), W'(1));
            check("t4_next", W'(srv_src[base + 3]), W'(4));
            check("t4_last", W'(srv_src[base + 4]), W'(0));
        end
        wait_idle(40);

        // Stall: source 3 drops valid mid-packet, lock is kept and source 0 is ignored.
        base = srv_src.size();
        load(3, 2, 32'h5300_0000);
        wait_capture(base + 1, 20);
        hold[3] = 1'b1;
        drive();
        wait_idle(40);
        check("t5_grant_held", W'(grant_o), W'(5'b01000));
        load(0, 1, 32'h5000_0000);
        for (int n = 0; n < 15; n++) step();
        check("t5_ignored", W'(srv_src.size()), W'(base + 1));
        check("t5_grant_still", W'(grant_o), W'(5'b01000));
        check("t5_busy", W'(busy_o), W'(0));
        hold[3] = 1'b0;
        drive();
        wait_capture(base + 2, 20);
        if (srv_src.size() >= base + 2) check("t5_resume", W'(srv_src[base + 1]), W'(3));
        wait_capture(base + 3, 40);
        if (srv_src.size() >= base + 3) check("t5_after", W'(srv_src[base + 2]), W'(0));
        wait_idle(40);

        // Watchdog with ack stuck low.
        ack_auto = 1'b0;
        load(2, 1, 32'h6200_0000);
        wait_req(20);
        for (int n = 0; n < 8; n++) step();
        check("t6_early", W'(timeout_o), W'(0));
        for (int n = 0; n < 12; n++) step();
        check("t6_fired", W'(timeout_o), W'(EXP_TO));
        for (int n = 0; n < 5; n++) step();
        check("t6_sticky", W'(timeout_o), W'(EXP_TO));
        ack_auto = 1'b1;
        wait_idle(40);
        check("t6_after_ack", W'(timeout_o), W'(EXP_TO));
        do_reset();
        #1;
        check("t6_reset_clr", W'(timeout_o), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
